mc_control: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables for that step: pc_wr, ir_wr, rf_wr, dm_req, dm_wr.
- Keeps the single-cycle select encodings.
- Adds a memory ready handshake with a parametrised timeout, illegal-instruction detection and a retired-instruction counter.
- Sits between the IR (opcode/funct source) and the multi-cycle datapath.

---
 rtl/mc_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle main controller.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables and selects for the current step. It also handles the data
// memory ready handshake with a bounded wait, flags undecodable instructions
// and counts retired instructions.
//
// Memory handshake: in MEM, dm_req stays high until mem_ready is sampled high
// at a rising edge; that edge completes the access. mem_ready is ignored in
// every other state.
module mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_op,
  output logic [1:0]       wr_sel,
  output logic [1:0]       wd_sel,
  output logic             rf_wr,
  output logic             b_sel,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             dm_req,
  output logic             dm_wr,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ADD, C_SUB, C_JR, C_ORI, C_LW, C_SW, C_LUI, C_BEQ, C_J, C_JAL, C_ILL
  } cls_e;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  cls_e        dec_cls;
  logic        timeout_hit;
  logic        pc_wr_c, ir_wr_c, rf_wr_c, dm_req_c, dm_wr_c, done_c, illegal_c;
  logic [1:0]  npc_op_c, wr_sel_c, wd_sel_c;
  logic        b_sel_c, ext_op_c;
  logic [2:0]  alu_op_c;

  // ALU operation chosen by instruction class.
  function automatic logic [2:0] alu_of(cls_e c);
    case (c)
      C_ADD, C_LW, C_SW: alu_of = 3'b000;
      C_SUB:             alu_of = 3'b001;
      C_ORI:             alu_of = 3'b011;
      C_LUI:             alu_of = 3'b100;
      default:           alu_of = 3'b101;
    endcase
  endfunction

  // Immediate operand for I-type arithmetic and memory accesses.
  function automatic logic b_of(cls_e c);
    b_of = (c == C_ORI) || (c == C_LW) || (c == C_SW) || (c == C_LUI);
  endfunction

  // Only address calculations sign-extend; ori/lui use the raw immediate.
  function automatic logic ext_of(cls_e c);
    ext_of = (c == C_LW) || (c == C_SW);
  endfunction

  // Classify the live IR fields; only consumed while in DECODE.
  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: dec_cls = C_ADD;
          6'b100010: dec_cls = C_SUB;
          6'b001000: dec_cls = C_JR;
          6'b000000: dec_cls = C_NOP;
          default:   dec_cls = C_ILL;
        endcase
      end
      6'b001101: dec_cls = C_ORI;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b001111: dec_cls = C_LUI;
      6'b000100: dec_cls = C_BEQ;
      6'b000010: dec_cls = C_J;
      6'b000011: dec_cls = C_JAL;
      default:   dec_cls = C_ILL;
    endcase
  end

  // The final permitted MEM wait cycle without mem_ready ends in HALT.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next state and per-step datapath controls.
  always_comb begin
    state_d   = state_q;
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    rf_wr_c   = 1'b0;
    dm_req_c  = 1'b0;
    dm_wr_c   = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    npc_op_c  = 2'b00;
    wr_sel_c  = 2'b00;
    wd_sel_c  = 2'b00;
    b_sel_c   = 1'b0;
    ext_op_c  = 1'b0;
    alu_op_c  = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (dec_cls)
          C_J, C_JR, C_NOP, C_ILL: begin
            pc_wr_c   = 1'b1;
            done_c    = 1'b1;
            illegal_c = (dec_cls == C_ILL);
            npc_op_c  = (dec_cls == C_J)  ? 2'b10 :
                        (dec_cls == C_JR) ? 2'b11 : 2'b00;
            state_d   = S_FETCH;
          end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_op_c = alu_of(cls_q);
        b_sel_c  = b_of(cls_q);
        ext_op_c = ext_of(cls_q);
        if (cls_q == C_BEQ) begin
          pc_wr_c  = 1'b1;
          npc_op_c = zero ? 2'b01 : 2'b00;
          done_c   = 1'b1;
          state_d  = S_FETCH;
        end else if ((cls_q == C_LW) || (cls_q == C_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_req_c = 1'b1;
        dm_wr_c  = (cls_q == C_SW);
        b_sel_c  = 1'b1;
        ext_op_c = 1'b1;
        alu_op_c = 3'b000;
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            pc_wr_c = 1'b1;
            done_c  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_wr_c  = 1'b1;
        pc_wr_c  = 1'b1;
        done_c   = 1'b1;
        alu_op_c = alu_of(cls_q);
        b_sel_c  = b_of(cls_q);
        ext_op_c = ext_of(cls_q);
        case (cls_q)
          C_ADD, C_SUB: wr_sel_c = 2'b01;
          C_LW:         wd_sel_c = 2'b01;
          C_JAL: begin
            wr_sel_c = 2'b10;
            wd_sel_c = 2'b10;
            npc_op_c = 2'b10;
          end
          default: wr_sel_c = 2'b00;
        endcase
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Bookkeeping next values: class latch, MEM wait counter, error flag, counter.
  always_comb begin
    cls_d     = (state_q == S_DECODE) ? dec_cls : cls_q;
    wait_d    = ((state_q == S_MEM) && (state_d == S_MEM)) ? wait_q + WAIT_W'(1) : '0;
    mem_err_d = mem_err_q || ((state_q == S_MEM) && (state_d == S_HALT));
    retired_d = done_c ? retired_q + CNT_W'(1) : retired_q;
  end

  // Controller state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NOP;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  // Enables and pulses are held low for as long as reset is asserted.
  assign pc_wr      = reset & pc_wr_c;
  assign ir_wr      = reset & ir_wr_c;
  assign rf_wr      = reset & rf_wr_c;
  assign dm_req     = reset & dm_req_c;
  assign dm_wr      = reset & dm_wr_c;
  assign instr_done = reset & done_c;
  assign illegal    = reset & illegal_c;
  assign npc_op     = npc_op_c;
  assign wr_sel     = wr_sel_c;
  assign wd_sel     = wd_sel_c;
  assign b_sel      = b_sel_c;
  assign ext_op     = ext_op_c;
  assign alu_op     = alu_op_c;
  assign state      = state_q;
  assign mem_err    = mem_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each task walks one scenario cycle by cycle
// and compares outputs against hand-derived values.
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_wr, ir_wr, rf_wr, b_sel, ext_op, dm_req, dm_wr;
  logic        instr_done, illegal, mem_err;
  logic [1:0]  npc_op, wr_sel, wd_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  mc_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_op(npc_op),
    .wr_sel(wr_sel), .wd_sel(wd_sel), .rf_wr(rf_wr), .b_sel(b_sel),
    .ext_op(ext_op), .alu_op(alu_op), .dm_req(dm_req), .dm_wr(dm_wr),
    .state(state), .instr_done(instr_done), .illegal(illegal),
    .mem_err(mem_err), .retired(retired)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    checks++;
    if ({state, ir_wr, pc_wr, rf_wr, dm_req, instr_done} !== {3'b000, 5'b00000}) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", {state, ir_wr, pc_wr, rf_wr, dm_req, instr_done}, 8'b0);
    end
    checks++;
    if ({retired, mem_err} !== 33'd0) begin
      errors++; $display("FAIL reset_counters got ret=%0d err=%b exp 0 0", retired, mem_err);
    end
    cyc();
    reset = 1'b1;
    #1;
    checks++;
    if ({state, ir_wr} !== 4'b0001) begin
      errors++; $display("FAIL reset_release_fetch got %b exp %b", {state, ir_wr}, 4'b0001);
    end
    opcode = 6'b100011;
    cyc(); cyc(); cyc();
    #1;
    checks++;
    if ({state, dm_req} !== 4'b0111) begin
      errors++; $display("FAIL reset_reach_mem got %b exp %b", {state, dm_req}, 4'b0111);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, dm_req, ir_wr} !== 5'b00000) begin
      errors++; $display("FAIL reset_mid_mem got %b exp %b", {state, dm_req, ir_wr}, 5'b00000);
    end
    cyc();
    reset = 1'b1;
    #1;
    checks++;
    if ({state, ir_wr, retired} !== {3'b000, 1'b1, 32'd0}) begin
      errors++; $display("FAIL reset_refetch got st=%b ir=%b ret=%0d exp 000 1 0", state, ir_wr, retired);
    end
    cyc();
    #1;
    checks++;
    if (state !== 3'b001) begin
      errors++; $display("FAIL reset_first_edge got %b exp 001", state);
    end
    do_reset();
    exp_ret = 0;
  endtask

  task automatic test_add();
    opcode = 6'b000000; funct = 6'b100000;
    #1;
    checks++;
    if ({state, ir_wr} !== 4'b0001) begin
      errors++; $display("FAIL add_fetch got %b exp 0001", {state, ir_wr});
    end
    cyc(); #1;
    checks++;
    if ({state, pc_wr, rf_wr} !== 5'b00100) begin
      errors++; $display("FAIL add_decode got %b exp 00100", {state, pc_wr, rf_wr});
    end
    cyc(); #1;
    checks++;
    if ({state, alu_op, b_sel} !== 7'b0100000) begin
      errors++; $display("FAIL add_exec got %b exp 0100000", {state, alu_op, b_sel});
    end
    cyc(); #1;
    checks++;
    if ({state, rf_wr, wr_sel, wd_sel, alu_op, pc_wr, instr_done} !== 13'b100_1_01_00_000_1_1) begin
      errors++; $display("FAIL add_wb got %b exp 1001010000011", {state, rf_wr, wr_sel, wd_sel, alu_op, pc_wr, instr_done});
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("FAIL add_ret_before got %0d exp 0", retired);
    end
    cyc(); exp_ret++; #1;
    checks++;
    if ({state, retired} !== {3'b000, 32'd1}) begin
      errors++; $display("FAIL add_ret_after got st=%b ret=%0d exp 000 1", state, retired);
    end
  endtask

  task automatic test_lw();
    int cyc_n, dm_n, wr_seen, done;
    logic [1:0] wd_done;
    cyc_n = 0; dm_n = 0; wr_seen = 0; done = 0; wd_done = 2'b11;
    opcode = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 30 && done == 0; i++) begin
      mem_ready = (dm_n == 3);
      #1;
      cyc_n++;
      if (dm_req) begin dm_n++; if (dm_wr) wr_seen = 1; end
      if (instr_done) begin done = 1; wd_done = wd_sel; end
      cyc();
    end
    mem_ready = 1'b0;
    exp_ret++;
    checks++;
    if (done != 1 || cyc_n != 8) begin
      errors++; $display("FAIL lw_cycles got %0d done=%0d exp 8", cyc_n, done);
    end
    checks++;
    if (dm_n != 4 || wr_seen != 0) begin
      errors++; $display("FAIL lw_dm got req=%0d wr=%0d exp 4 0", dm_n, wr_seen);
    end
    checks++;
    if (wd_done !== 2'b01) begin
      errors++; $display("FAIL lw_wd_sel got %b exp 01", wd_done);
    end
    #1;
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL lw_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_beq();
    int cyc_n, done;
    logic [1:0] npc_done;
    opcode = 6'b000100; funct = 6'd0; zero = 1'b1;
    cyc(); cyc(); #1;
    checks++;
    if ({state, pc_wr, npc_op, instr_done, alu_op} !== 10'b010_1_01_1_101) begin
      errors++; $display("FAIL beq_taken got %b exp 0101011101", {state, pc_wr, npc_op, instr_done, alu_op});
    end
    cyc(); exp_ret++; #1;
    checks++;
    if ({state, retired} !== {3'b000, exp_ret[31:0]}) begin
      errors++; $display("FAIL beq_taken_end got st=%b ret=%0d exp 000 %0d", state, retired, exp_ret);
    end
    zero = 1'b0; cyc_n = 0; done = 0; npc_done = 2'b11;
    for (int i = 0; i < 10 && done == 0; i++) begin
      #1;
      cyc_n++;
      if (instr_done) begin done = 1; npc_done = npc_op; end
      cyc();
    end
    exp_ret++;
    checks++;
    if (cyc_n != 3 || done != 1 || npc_done !== 2'b00) begin
      errors++; $display("FAIL beq_not_taken got cyc=%0d npc=%b exp 3 00", cyc_n, npc_done);
    end
  endtask

  task automatic test_jal_illegal();
    opcode = 6'b000011; funct = 6'd0;
    cyc(); #1;
    checks++;
    if ({state, pc_wr, instr_done} !== 5'b00100) begin
      errors++; $display("FAIL jal_decode got %b exp 00100", {state, pc_wr, instr_done});
    end
    cyc(); #1;
    checks++;
    if ({state, rf_wr, wr_sel, wd_sel, npc_op, instr_done} !== 11'b100_1_10_10_10_1) begin
      errors++; $display("FAIL jal_wb got %b exp 10011010101", {state, rf_wr, wr_sel, wd_sel, npc_op, instr_done});
    end
    cyc(); exp_ret++;
    opcode = 6'b111111;
    cyc(); #1;
    checks++;
    if ({illegal, pc_wr, npc_op, instr_done, rf_wr, dm_req} !== 7'b1100100) begin
      errors++; $display("FAIL illegal_decode got %b exp 1100100", {illegal, pc_wr, npc_op, instr_done, rf_wr, dm_req});
    end
    cyc(); exp_ret++; #1;
    checks++;
    if ({state, illegal, rf_wr, retired} !== {5'b00000, exp_ret[31:0]}) begin
      errors++; $display("FAIL illegal_after got st=%b ill=%b rf=%b ret=%0d exp 000 0 0 %0d", state, illegal, rf_wr, retired, exp_ret);
    end
  endtask

  task automatic test_jumps();
    opcode = 6'b000010; funct = 6'd0;
    cyc(); #1;
    checks++;
    if ({npc_op, pc_wr, instr_done, illegal} !== 5'b10110) begin
      errors++; $display("FAIL j_decode got %b exp 10110", {npc_op, pc_wr, instr_done, illegal});
    end
    cyc(); exp_ret++;
    opcode = 6'b000000; funct = 6'b001000;
    cyc(); #1;
    checks++;
    if ({npc_op, pc_wr, instr_done, illegal} !== 5'b11110) begin
      errors++; $display("FAIL jr_decode got %b exp 11110", {npc_op, pc_wr, instr_done, illegal});
    end
    cyc(); exp_ret++;
    funct = 6'b100001;
    cyc(); #1;
    checks++;
    if ({npc_op, pc_wr, instr_done, illegal} !== 5'b00111) begin
      errors++; $display("FAIL rtype_bad_funct got %b exp 00111", {npc_op, pc_wr, instr_done, illegal});
    end
    cyc(); exp_ret++;
    funct = 6'b000000;
    cyc(); #1;
    checks++;
    if ({npc_op, pc_wr, instr_done, illegal} !== 5'b00110) begin
      errors++; $display("FAIL nop_decode got %b exp 00110", {npc_op, pc_wr, instr_done, illegal});
    end
    cyc(); exp_ret++; #1;
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL jumps_retired got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    logic [4:0] exp_ex [3];
    logic [3:0] exp_wb [3];
    int cyc_n, done;
    logic [4:0] got_ex;
    logic [3:0] got_wb;
    ops[0] = 6'b001101; fns[0] = 6'd0;       exp_ex[0] = 5'b011_1_0; exp_wb[0] = 4'b00_00;
    ops[1] = 6'b001111; fns[1] = 6'd0;       exp_ex[1] = 5'b100_1_0; exp_wb[1] = 4'b00_00;
    ops[2] = 6'b000000; fns[2] = 6'b100010;  exp_ex[2] = 5'b001_0_0; exp_wb[2] = 4'b01_00;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k]; funct = fns[k];
      cyc_n = 0; done = 0; got_ex = 5'b11111; got_wb = 4'b1111;
      for (int i = 0; i < 10 && done == 0; i++) begin
        #1;
        cyc_n++;
        if (state == 3'b010) got_ex = {alu_op, b_sel, ext_op};
        if (instr_done) begin done = 1; got_wb = {wr_sel, wd_sel}; end
        cyc();
      end
      exp_ret++;
      checks++;
      if (cyc_n != 4 || got_ex !== exp_ex[k] || got_wb !== exp_wb[k]) begin
        errors++; $display("FAIL b2b_%0d got cyc=%0d ex=%b wb=%b exp 4 %b %b", k, cyc_n, got_ex, got_wb, exp_ex[k], exp_wb[k]);
      end
    end
    #1;
    checks++;
    if ({state, ir_wr, retired} !== {4'b0001, exp_ret[31:0]}) begin
      errors++; $display("FAIL b2b_end got st=%b ir=%b ret=%0d exp 000 1 %0d", state, ir_wr, retired, exp_ret);
    end
  endtask

  task automatic test_sw_late_ready();
    int mem_n, done, wr_seen;
    mem_n = 0; done = 0; wr_seen = 0;
    opcode = 6'b101011; funct = 6'd0;
    for (int i = 0; i < 40 && done == 0; i++) begin
      mem_ready = (mem_n == 14);
      #1;
      if (dm_req) begin mem_n++; if (dm_wr) wr_seen = 1; end
      if (instr_done) done = 1;
      cyc();
    end
    mem_ready = 1'b0;
    exp_ret++;
    #1;
    checks++;
    if (done != 1 || mem_n != 15 || wr_seen != 1) begin
      errors++; $display("FAIL sw_late_ready got done=%0d mem=%0d wr=%0d exp 1 15 1", done, mem_n, wr_seen);
    end
    checks++;
    if ({state, mem_err, retired} !== {4'b0000, exp_ret[31:0]}) begin
      errors++; $display("FAIL sw_late_end got st=%b err=%b ret=%0d exp 000 0 %0d", state, mem_err, retired, exp_ret);
    end
  endtask

  task automatic test_timeout();
    int mem_n, halted;
    mem_n = 0; halted = 0;
    opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b0;
    for (int i = 0; i < 40 && halted == 0; i++) begin
      #1;
      if (state == 3'b101) halted = 1;
      else begin
        if (state == 3'b011) mem_n++;
        cyc();
      end
    end
    checks++;
    if (halted != 1 || mem_n != 15 || mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_halt got halt=%0d mem=%0d err=%b exp 1 15 1", halted, mem_n, mem_err);
    end
    mem_ready = 1'b1;
    cyc(); cyc(); cyc(); #1;
    checks++;
    if ({state, mem_err, pc_wr, ir_wr, rf_wr, dm_req, instr_done} !== 9'b101_1_00000) begin
      errors++; $display("FAIL timeout_hold got %b exp 101100000", {state, mem_err, pc_wr, ir_wr, rf_wr, dm_req, instr_done});
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL timeout_retired got %0d exp %0d", retired, exp_ret);
    end
    mem_ready = 1'b0;
    do_reset();
    exp_ret = 0;
    #1;
    checks++;
    if ({state, mem_err, retired} !== 36'd0) begin
      errors++; $display("FAIL timeout_reset got st=%b err=%b ret=%0d exp 000 0 0", state, mem_err, retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jal_illegal();
    test_jumps();
    test_back_to_back();
    test_sw_late_ready();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
